// File: rtl/stoch_exp_if.sv
// Handshake and stream bundle for the stochastic e^(-x) unit.
// The bench or upstream stage is the master; the core is the slave.
interface stoch_exp_if #(
  parameter int ORDER  = 5,
  parameter int COEF_W = 8,
  parameter int WIN_W  = 10
);
  logic                        en;
  logic                        x;
  logic                        ext_mode;
  logic [(ORDER-1)*COEF_W-1:0] coef;
  logic [ORDER-2:0]            a_ext;
  logic                        start;
  logic                        y;
  logic                        busy;
  logic                        done;
  logic [WIN_W-1:0]            result;

  modport master (
    output en, x, ext_mode, coef, a_ext, start,
    input  y, busy, done, result
  );

  modport slave (
    input  en, x, ext_mode, coef, a_ext, start,
    output y, busy, done, result
  );
endinterface

// File: rtl/stoch_exp_core.sv
// Stochastic-bitstream e^(-x): Horner/NAND chain over a delayed x stream,
// per-stage LFSR SNG coefficients, and a windowed ones-counter estimator.
module stoch_exp_core #(
  parameter int          ORDER  = 5,
  parameter int          COEF_W = 8,
  parameter int unsigned SEED   = 'hA5,
  parameter int          WIN_W  = 10
) (
  input  logic      clk,
  input  logic      n_rst,
  stoch_exp_if.slave bus
);
  localparam int NC    = ORDER - 1;
  localparam int CNT_W = WIN_W + 1;
  localparam logic [CNT_W-1:0]  N_LAST    = CNT_W'((1 << WIN_W) - 1);
  localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(ORDER - 1);
  localparam logic [COEF_W-1:0] TAPS      = (COEF_W == 16) ? COEF_W'(32'hD008)
                                                           : COEF_W'(32'h00B8);

  typedef enum logic [1:0] {IDLE, WARM, RUN, DONE} state_t;

  function automatic logic [COEF_W-1:0] seed_of(input int j);
    logic [COEF_W-1:0] s;
    s = COEF_W'(SEED + 37 * j);
    return (s == '0) ? COEF_W'(1) : s;
  endfunction

  function automatic logic [COEF_W-1:0] lfsr_step(input logic [COEF_W-1:0] s);
    return {s[COEF_W-2:0], ^(s & TAPS)};
  endfunction

  // The ones counter can reach exactly N, one past the result range.
  function automatic logic [WIN_W-1:0] sat_count(input logic [CNT_W-1:0] v);
    return v[WIN_W] ? '1 : v[WIN_W-1:0];
  endfunction

  logic [COEF_W-1:0] lfsr [NC];
  logic [NC-1:0]     s_p0;
  logic [NC-1:0]     c_p0;
  logic [ORDER-1:0]  xd_p0;
  logic              z_top_p0;
  logic              y_p1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  ones;
  logic              busy_r;
  logic              done_r;
  logic [WIN_W-1:0]  result_r;

  // ---- stage p0: SNG compare, coefficient select, NAND chain ----
  always_comb begin
    logic acc;
    for (int j = 0; j < NC; j++) begin
      s_p0[j] = lfsr[j] < bus.coef[j*COEF_W +: COEF_W];
    end
    c_p0 = bus.ext_mode ? bus.a_ext : s_p0;
    acc  = ~(c_p0[NC-1] & xd_p0[0]);
    for (int k = 1; k <= ORDER - 2; k++) begin
      acc = ~(c_p0[NC-1-k] & acc & xd_p0[k]);
    end
    z_top_p0 = ~(acc & xd_p0[ORDER-1]);
  end

  // ---- stage p1: delay line, LFSRs and registered y ----
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      xd_p0 <= '0;
      y_p1  <= 1'b0;
      for (int j = 0; j < NC; j++) lfsr[j] <= seed_of(j);
    end else if (bus.en) begin
      xd_p0 <= {bus.x, xd_p0[ORDER-1:1]};
      y_p1  <= z_top_p0;
      for (int j = 0; j < NC; j++) lfsr[j] <= lfsr_step(lfsr[j]);
    end
  end

  // Window control; cnt counts flush cycles in WARM, then samples in RUN.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ones     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (bus.en) begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              state  <= WARM;
              busy_r <= 1'b1;
              cnt    <= '0;
              ones   <= '0;
            end
          end
          WARM: begin
            if (cnt == WARM_LAST) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RUN: begin
            ones <= ones + CNT_W'(y_p1);
            cnt  <= cnt + CNT_W'(1);
            if (cnt == N_LAST) begin
              state  <= DONE;
              busy_r <= 1'b0;
            end
          end
          DONE: begin
            result_r <= sat_count(ones);
            done_r   <= 1'b1;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.y      = y_p1;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
endmodule

// File: tb/tb_stoch_exp_core.sv
// Directed bench for stoch_exp_core: constant streams, statistical window,
// enable gating, start filtering and mid-window reset.
module tb_stoch_exp_core;
  localparam int ORDER  = 5;
  localparam int COEF_W = 8;
  localparam int WIN_W  = 10;
  localparam int N      = 1 << WIN_W;
  localparam int LAT    = ORDER + N + 1;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  stoch_exp_if #(.ORDER(ORDER), .COEF_W(COEF_W), .WIN_W(WIN_W)) bus ();

  stoch_exp_core #(
    .ORDER(ORDER), .COEF_W(COEF_W), .SEED(32'hA5), .WIN_W(WIN_W)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int k_en   = 0;
  int frz_bad = 0;
  bit x_mode = 1'b0;
  bit en_mode = 1'b0;
  bit xseq [4096];

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    logic en_was, y_was, busy_was;
    en_was   = bus.en;
    y_was    = bus.y;
    busy_was = bus.busy;
    @(posedge clk);
    #1;
    if (!en_was && (bus.y !== y_was || bus.busy !== busy_was)) frz_bad++;
    if (en_was) k_en++;
    if (x_mode) bus.x = xseq[k_en % 4096];
    if (en_mode) bus.en = ~bus.en;
  endtask

  task automatic do_reset();
    bus.en = 1'b0;
    n_rst  = 1'b0;
    step();
    step();
    n_rst = 1'b1;
    k_en  = 0;
    if (x_mode) bus.x = xseq[0];
  endtask

  task automatic run_window(output int cyc, output int res, output int y_hi, output int y_lo);
    cyc  = 0;
    y_hi = 0;
    y_lo = 0;
    while (!bus.en) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (!bus.done && cyc < 5000) begin
      if (bus.en) cyc++;
      step();
      if (cyc >= 8) begin
        if (bus.y) y_hi++;
        else       y_lo++;
      end
    end
    res = int'(bus.result);
  endtask

  initial begin
    int cyc, res, y_hi, y_lo, r_a, dones, busy_hi;
    for (int i = 0; i < 4096; i++) xseq[i] = 1'($urandom_range(0, 1));
    bus.x        = 1'b0;
    bus.ext_mode = 1'b0;
    bus.coef     = {8'd51, 8'd64, 8'd85, 8'd128};
    bus.a_ext    = '0;
    bus.start    = 1'b0;
    do_reset();
    chk("rst_y", bus.y, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);

    // x=0: y stuck at 1, count saturates.
    bus.en = 1'b1;
    run_window(cyc, res, y_hi, y_lo);
    chk("t1_done_seen", bus.done, 1);
    chk("t1_latency", cyc, LAT);
    chk("t1_result", res, 1023);
    chk("t1_y_zeros", y_lo, 0);
    step();
    chk("t1_done_pulse", bus.done, 0);
    chk("t1_busy_after", bus.busy, 0);
    chk("t1_result_hold", bus.result, 1023);

    // x=1, all coefficients 1: chain alternates and y=0.
    bus.x = 1'b1;
    bus.ext_mode = 1'b1;
    bus.a_ext = 4'b1111;
    run_window(cyc, res, y_hi, y_lo);
    chk("t2_latency", cyc, LAT);
    chk("t2_result", res, 0);
    chk("t2_y_ones", y_hi, 0);

    // x=1, all coefficients 0: lower stages all 1, top NAND gives 0.
    bus.a_ext = 4'b0000;
    run_window(cyc, res, y_hi, y_lo);
    chk("t3_result", res, 0);
    chk("t3_y_ones", y_hi, 0);

    // Random x at P=0.5 with internal Taylor coefficients: ~e^-0.5 * 1024.
    x_mode = 1'b1;
    bus.ext_mode = 1'b0;
    do_reset();
    bus.en = 1'b1;
    run_window(cyc, res, y_hi, y_lo);
    r_a = res;
    chk("t4_latency", cyc, LAT);
    chk("t4_in_range", int'(res >= 621 - 41 && res <= 621 + 41), 1);

    // Same stream with en toggling every cycle must give the same count.
    do_reset();
    bus.en  = 1'b1;
    frz_bad = 0;
    en_mode = 1'b1;
    run_window(cyc, res, y_hi, y_lo);
    en_mode = 1'b0;
    bus.en  = 1'b1;
    chk("t5_en_latency", cyc, LAT);
    chk("t5_same_result", res, r_a);
    chk("t5_frozen", frz_bad, 0);

    // Repeated start during a window: exactly one done.
    x_mode = 1'b0;
    bus.x  = 1'b0;
    dones  = 0;
    bus.start = 1'b1;
    step();
    for (int i = 0; i < 2300; i++) begin
      bus.start = (i == 100 || i == 300 || i == 700 || i == 1000) ? 1'b1 : 1'b0;
      step();
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    chk("t6_single_done", dones, 1);
    chk("t6_result", bus.result, 1023);

    // Reset in the middle of a window discards it.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < ORDER + 1 + 500; i++) step();
    chk("t6_busy_mid", bus.busy, 1);
    n_rst = 1'b0;
    #2;
    chk("t6_rst_y", bus.y, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_done", bus.done, 0);
    chk("t6_rst_result", bus.result, 0);
    step();
    n_rst   = 1'b1;
    dones   = 0;
    busy_hi = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (bus.done) dones++;
      if (bus.busy) busy_hi++;
    end
    chk("t6_no_done_after_rst", dones, 0);
    chk("t6_idle_after_rst", busy_hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
